weight_drm_reader: RTL and testbench
====================================

# weight_drm_reader

Read-side engine for the weight DRM: it takes a start command with a base address and word count and issues read addresses to the weight DRM read port. It absorbs the RAM's fixed read latency in a small credit-controlled FIFO and presents the weights as a valid/ready stream to the MAC array. It pairs with the weight write controller: that block fills the DRM, and this block drains it under backpressure.

## Interface
Parameters:
- RD_ADDR_DEPTH, 8, DRM read address width.
- DATA_WIDTH, 64, DRM read data width, which equals the stream width.
- RD_LATENCY, 2, DRM read latency in cycles, from `drm_rd_en` to `drm_rd_data` valid. Legal range is 1..3.

Ports:
- clk  in  1  single clock for the whole block.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous abort; on the cycle it is high, all state is cleared as if reset.
- start  in  1  one-cycle command pulse; accepted only when busy=0.
- base_addr  in  RD_ADDR_DEPTH  first read address, latched on accepted start.
- num_words  in  RD_ADDR_DEPTH+1  word count, 0..2^RD_ADDR_DEPTH, latched on accepted start.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse marking the end of a pass.
- drm_rd_en  out  1  read strobe to the DRM.
- drm_addr_rd  out  RD_ADDR_DEPTH  DRM read address.
- drm_rd_data  in  DATA_WIDTH  DRM read data, valid RD_LATENCY cycles after `drm_rd_en`.
- w_valid  out  1  stream data is valid.
- w_ready  in  1  consumer accepts the data.
- w_data  out  DATA_WIDTH  weight word.
- w_last  out  1  marks the final word of the pass.

## Operation
- States:
  - IDLE: waits for start.
  - ISSUE: issues reads.
  - DRAIN: all reads are issued; waits for the stream to empty.
  - DONE: one cycle, asserts `done`.
- IDLE→ISSUE on start with num_words≠0. IDLE→DONE on start with num_words=0; no reads and no stream beats occur.
- ISSUE→DRAIN on the cycle the last read is issued. DRAIN→DONE on the handshake of the `w_last` beat. DONE→IDLE unconditionally.
- A read is issued (`drm_rd_en`=1) in ISSUE only when `inflight + fifo_count < FIFO_DEPTH`.
  - FIFO_DEPTH = RD_LATENCY+2.
  - `inflight` counts reads issued whose data has not yet been written into the FIFO.
- The address increments by 1 per issued read and wraps modulo 2^RD_ADDR_DEPTH. Example: base 0xFE with 4 words reads FE, FF, 00, 01.
- A shift register of depth RD_LATENCY tracks the `drm_rd_en` history. Its tail writes `drm_rd_data` into the FIFO.
- Stream outputs:
  - `w_valid` = FIFO not empty.
  - `w_data` = FIFO head.
  - `w_last` = 1 when the head is the num_words-th word of the pass, tracked with a pop counter.
- The stream follows standard valid/ready rules. Once `w_valid` is high, it and `w_data` are held stable until the handshake; no combinational path runs from `w_ready` to `w_valid`.
- start while busy=1 is ignored.
- `flush` or rstn=0 takes priority over everything. It clears the FIFO, the counters and the pipeline, and returns to IDLE. Read data still in flight afterwards is discarded and is not written into the FIFO.

## Timing
- Reset and flush values: busy=0, done=0, drm_rd_en=0, drm_addr_rd=0, w_valid=0, w_data=0, w_last=0.
- Start accepted at cycle 0:
  - busy=1 from cycle 1 through the DONE cycle inclusive.
  - First `drm_rd_en` at cycle 1.
  - First `w_valid` at cycle RD_LATENCY+2.
- With `w_ready` held high, throughput is one word per cycle with no bubbles. An N-word pass asserts `done` at cycle N+RD_LATENCY+2, one cycle after the `w_last` handshake.
- With num_words=0, done=1 at cycle 1 and busy=1 only in cycle 1.
- A FIFO push and pop in the same cycle leaves the count unchanged. A pop from a full FIFO in the same cycle as a push is legal.
- After `done`, a new start is accepted the next cycle, when busy=0.

## Structure
- Shared package `weight_pkg`: RD_ADDR_DEPTH and DATA_WIDTH defaults, the state encoding (IDLE/ISSUE/DRAIN/DONE, 2 bits), and the FIFO_DEPTH function of RD_LATENCY.
- One sub-module, `weight_rd_fifo`: a synchronous FIFO with first-word-fall-through output, parameterized by width and depth, with a synchronous flush input.
- The FSM, the credit counter and the latency shift register stay in the top module.

## Test plan
- base=0x10, num=8, w_ready=1, RD_LATENCY=2 → reads 0x10..0x17 on cycles 1..8; w_valid on cycles 4..11 with data in address order; w_last on cycle 11; done on cycle 12.
- base=0xFE, num=4 → addresses FE, FF, 00, 01; w_last on the 4th beat.
- num=32 with w_ready toggling on a random pattern and held low for 10 cycles → inflight+fifo_count never exceeds 4; no word is lost or duplicated; w_valid/w_data stay stable while stalled.
- num=0 → done on cycle 1; drm_rd_en and w_valid stay 0.
- flush asserted mid-pass, after 5 of 16 words were accepted → next cycle busy=0 and w_valid=0; no stale beat appears later; a new start with base 0x40, num 2 streams exactly 2 correct words.
- start pulsed again while busy → ignored; the original pass completes unchanged with exactly one done.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared definitions for the weight DRM read path: default widths, FSM
// encoding and the read-FIFO sizing rule.
package weight_pkg;

  localparam int RD_ADDR_DEPTH_DEFAULT = 8;
  localparam int DATA_WIDTH_DEFAULT    = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Two spare slots beyond the read latency let the stream run at full rate.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/weight_rd_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
// The head reads as zero while empty so the stream data is clean when idle.
module weight_rd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 head,
  output logic                             not_empty,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/weight_drm_reader.sv
// Weight DRM read engine: issues a run of reads under a credit limit, absorbs
// the RAM latency in a small FIFO and streams the words out valid/ready.
module weight_drm_reader
  import weight_pkg::*;
#(
  parameter int RD_ADDR_DEPTH = RD_ADDR_DEPTH_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int RD_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     start,
  input  logic [RD_ADDR_DEPTH-1:0] base_addr,
  input  logic [RD_ADDR_DEPTH:0]   num_words,
  output logic                     busy,
  output logic                     done,
  output logic                     drm_rd_en,
  output logic [RD_ADDR_DEPTH-1:0] drm_addr_rd,
  input  logic [DATA_WIDTH-1:0]    drm_rd_data,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [DATA_WIDTH-1:0]    w_data,
  output logic                     w_last,
  output logic [1:0]               state_dbg
);

  // Stream handshake: a beat transfers on a cycle with w_valid && w_ready;
  // w_valid depends only on registered FIFO state, and w_valid/w_data hold
  // until that transfer.

  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  logic [1:0]               state;
  logic [RD_ADDR_DEPTH-1:0] rd_addr;
  logic [RD_ADDR_DEPTH:0]   num_q;
  logic [RD_ADDR_DEPTH:0]   issue_cnt;
  logic [RD_ADDR_DEPTH:0]   pop_cnt;
  logic [RD_LATENCY-1:0]    rd_pipe;
  logic [CW-1:0]            inflight;
  logic [CW-1:0]            fifo_count;
  logic [CW:0]              credit_sum;
  logic                     credit_ok;
  logic                     rd_fire;
  logic                     fifo_valid;
  logic                     beat;
  logic                     accept;

  assign accept     = start && (state == ST_IDLE);
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < (CW + 1)'(FIFO_DEPTH);
  assign rd_fire    = (state == ST_ISSUE) && credit_ok;
  assign beat       = fifo_valid && w_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(rd_pipe[i]);
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      num_q     <= '0;
      issue_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          rd_addr   <= base_addr;
          num_q     <= num_words;
          issue_cnt <= '0;
          state     <= (num_words == '0) ? ST_DONE : ST_ISSUE;
        end
        ST_ISSUE: if (rd_fire) begin
          rd_addr   <= rd_addr + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == num_q - 1'b1) state <= ST_DRAIN;
        end
        ST_DRAIN: if (beat && w_last) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush)  pop_cnt <= '0;
    else if (accept)     pop_cnt <= '0;
    else if (beat)       pop_cnt <= pop_cnt + 1'b1;
  end

  // Read-strobe history; the oldest bit marks the cycle the RAM data is valid.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_fire;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  weight_rd_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (rd_pipe[RD_LATENCY-1]),
    .push_data (drm_rd_data),
    .pop       (beat),
    .head      (w_data),
    .not_empty (fifo_valid),
    .count     (fifo_count)
  );

  assign w_valid     = fifo_valid;
  assign w_last      = fifo_valid && (pop_cnt == num_q - 1'b1);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign drm_rd_en   = rd_fire;
  assign drm_addr_rd = rd_addr;
  assign state_dbg   = state;

endmodule

// File: tb/tb_weight_drm_reader.sv
// Bench for weight_drm_reader: RAM model, randomized consumer, and a
// queue-based model of the words each pass must deliver.
module tb_weight_drm_reader;

  localparam int AW         = 8;
  localparam int DW         = 64;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = RD_LATENCY + 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, done, drm_rd_en, w_valid, w_last;
  logic          w_ready = 1'b0;
  logic [AW-1:0] drm_addr_rd;
  logic [DW-1:0] drm_rd_data, w_data;
  logic [1:0]    state_dbg;

  weight_drm_reader #(
    .RD_ADDR_DEPTH (AW),
    .DATA_WIDTH    (DW),
    .RD_LATENCY    (RD_LATENCY)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .drm_rd_en   (drm_rd_en),
    .drm_addr_rd (drm_addr_rd),
    .drm_rd_data (drm_rd_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .w_last      (w_last),
    .state_dbg   (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data for an address appears RD_LATENCY cycles after the strobe
  logic [DW-1:0] mem [256];
  logic [AW-1:0] addr_pipe [RD_LATENCY];
  always @(posedge clk) begin
    addr_pipe[0] <= drm_addr_rd;
    for (int i = 1; i < RD_LATENCY; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign drm_rd_data = mem[addr_pipe[RD_LATENCY-1]];

  // Consumer: 0 = always ready, 1 = random, 2 = stalled
  int ready_mode = 0;
  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       w_ready = 1'b1;
      1:       w_ready = 1'($urandom_range(0, 1));
      default: w_ready = 1'b0;
    endcase
  end

  // Scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_data_q [$];
  logic          exp_last_q [$];
  logic [AW-1:0] exp_addr_q [$];
  int            start_cyc = -1000;
  int            first_rd, first_valid, last_cyc, done_cyc, done_cnt, beat_cnt;
  int            outstanding = 0;
  logic          busy_at1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    if (rstn) begin
      if (cyc - start_cyc == 1) busy_at1 = busy;
      if (flush) begin
        exp_data_q.delete();
        exp_last_q.delete();
        exp_addr_q.delete();
        outstanding = 0;
        prev_stall  = 1'b0;
      end else begin
        if (drm_rd_en) begin
          check("read_expected", 64'(exp_addr_q.size() != 0), 64'd1);
          if (exp_addr_q.size() != 0) check("rd_addr", 64'(drm_addr_rd), 64'(exp_addr_q.pop_front()));
          outstanding++;
          if (first_rd < 0) first_rd = cyc - start_cyc;
        end
        check("credit_limit", 64'(outstanding <= FIFO_DEPTH), 64'd1);
        if (prev_stall) begin
          check("hold_valid", 64'(w_valid), 64'd1);
          check("hold_data", w_data, prev_data);
        end
        if (w_valid) begin
          check("beat_expected", 64'(exp_data_q.size() != 0), 64'd1);
          if (exp_data_q.size() != 0) begin
            check("w_data", w_data, exp_data_q[0]);
            check("w_last", 64'(w_last), 64'(exp_last_q[0]));
          end
          if (first_valid < 0) first_valid = cyc - start_cyc;
          if (w_ready) begin
            if (exp_data_q.size() != 0) begin
              void'(exp_data_q.pop_front());
              void'(exp_last_q.pop_front());
            end
            outstanding--;
            beat_cnt++;
            if (w_last) last_cyc = cyc - start_cyc;
          end
        end else begin
          check("last_without_valid", 64'(w_last), 64'd0);
        end
        prev_stall = w_valid && !w_ready;
        prev_data  = w_data;
        if (done) begin
          done_cnt++;
          done_cyc = cyc - start_cyc;
        end
      end
    end
  end

  // Driver tasks
  task automatic start_pass(input logic [AW-1:0] base, input int num);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    num_words = (AW+1)'(num);
    start_cyc = cyc;
    first_rd = -1; first_valid = -1; last_cyc = -1; done_cyc = -1;
    done_cnt = 0; beat_cnt = 0; busy_at1 = 1'b0;
    for (int i = 0; i < num; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
      exp_last_q.push_back(i == num - 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    check("done_seen", 64'(done_cnt), 64'd1);
    @(negedge clk); #1;
    check("idle_after_done", 64'(busy), 64'd0);
    check("data_drained", 64'(exp_data_q.size()), 64'd0);
    check("reads_drained", 64'(exp_addr_q.size()), 64'd0);
  endtask

  task automatic wait_beats(input int n, input int limit);
    int k = 0;
    while (beat_cnt < n && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    check("beats_reached", 64'(beat_cnt), 64'(n));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(drm_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(drm_addr_rd), 64'd0);
    check({tag, "_valid"}, 64'(w_valid), 64'd0);
    check({tag, "_data"}, w_data, 64'd0);
    check({tag, "_last"}, 64'(w_last), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Directed: base 0x10, 8 words, always ready
    ready_mode = 0;
    start_pass(8'h10, 8);
    wait_done(100);
    check("t1_busy_c1", 64'(busy_at1), 64'd1);
    check("t1_first_rd", 64'(first_rd), 64'd1);
    check("t1_first_valid", 64'(first_valid), 64'd4);
    check("t1_last_cyc", 64'(last_cyc), 64'd11);
    check("t1_done_cyc", 64'(done_cyc), 64'd12);
    check("t1_beats", 64'(beat_cnt), 64'd8);

    // Address wrap
    start_pass(8'hFE, 4);
    wait_done(100);
    check("t2_last_cyc", 64'(last_cyc), 64'd7);
    check("t2_done_cyc", 64'(done_cyc), 64'd8);
    check("t2_beats", 64'(beat_cnt), 64'd4);

    // 32 words, random backpressure with a 10-cycle stall
    ready_mode = 1;
    start_pass(AW'($urandom_range(0, 255)), 32);
    repeat (12) @(posedge clk);
    ready_mode = 2;
    repeat (10) @(posedge clk);
    ready_mode = 1;
    wait_done(2000);
    check("t3_beats", 64'(beat_cnt), 64'd32);

    // Zero-length pass
    start_pass(AW'($urandom_range(0, 255)), 0);
    wait_done(50);
    check("t4_done_cyc", 64'(done_cyc), 64'd1);
    check("t4_busy_c1", 64'(busy_at1), 64'd1);
    check("t4_beats", 64'(beat_cnt), 64'd0);
    check("t4_first_rd", 64'(first_rd), 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush after 5 of 16 words
    ready_mode = 1;
    start_pass(8'h20, 16);
    wait_beats(5, 500);
    ready_mode = 2;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    ready_mode = 0;
    @(negedge clk); #1;
    check_quiet("flush");
    check("flush_beats", 64'(beat_cnt), 64'd5);
    repeat (10) @(negedge clk);
    start_pass(8'h40, 2);
    wait_done(100);
    check("t5_beats", 64'(beat_cnt), 64'd2);

    // Start while busy is ignored
    start_pass(8'h80, 6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h33; num_words = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    check("t6_beats", 64'(beat_cnt), 64'd6);
    repeat (8) @(negedge clk);
    check("t6_done_count", 64'(done_cnt), 64'd1);

    // Random passes under random backpressure
    for (int p = 0; p < 4; p++) begin
      int n;
      n = $urandom_range(1, 40);
      ready_mode = 1;
      start_pass(AW'($urandom_range(0, 255)), n);
      wait_done(3000);
      check("rand_beats", 64'(beat_cnt), 64'(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
